// File: rtl/payload_byte_streamer.sv
// Serializes AXI4-Stream payload words into one byte per cycle for the PCRE
// engines, framing each packet with sod, a flush cycle and an eod strobe.
module payload_byte_streamer #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tkeep,
    input  logic                  s_tlast,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  hold,
    output logic                  sod,
    output logic                  en,
    output logic [7:0]            char_byte,
    output logic [255:0]          char_dec,
    output logic                  eod
);

    localparam int IW = (KEEP_WIDTH > 1) ? $clog2(KEEP_WIDTH) : 1;

    // State names the action taken at the next edge where hold is low.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BYTES,
        ST_FLUSH,
        ST_EOD
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  bf_q, bf_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [KEEP_WIDTH-1:0] keep_q, keep_d;
    logic                  last_q, last_d;
    logic                  tready_q, tready_d;
    logic                  sod_q, sod_d;
    logic                  en_q, en_d;
    logic                  eod_q, eod_d;
    logic [7:0]            byte_q, byte_d;
    logic [255:0]          dec_q, dec_d;
    logic                  dat_d;

    logic                  acc;
    logic                  cur_valid;
    logic [DATA_WIDTH-1:0] cur_data;
    logic [KEEP_WIDTH-1:0] cur_keep;
    logic                  cur_last;
    logic [IW-1:0]         cur_hi;
    logic [7:0]            lanes [KEEP_WIDTH];

    function automatic logic [IW-1:0] hi_lane(
        input logic [KEEP_WIDTH-1:0] k
    );
        hi_lane = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (k[i]) hi_lane = IW'(i);
        end
    endfunction

    assign s_tready  = tready_q & ~rst;
    assign acc       = s_tvalid & s_tready;
    assign sod       = sod_q;
    assign en        = en_q;
    assign eod       = eod_q;
    assign char_byte = byte_q;
    assign char_dec  = dec_q;

    // A word accepted this cycle is usable at once; tready implies bf_q=0.
    assign cur_valid = bf_q | acc;
    assign cur_data  = bf_q ? data_q : s_tdata;
    assign cur_keep  = bf_q ? keep_q : s_tkeep;
    assign cur_last  = bf_q ? last_q : s_tlast;
    assign cur_hi    = hi_lane(cur_keep);

    always_comb begin
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            lanes[i] = cur_data[i*8 +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bf_d    = cur_valid;
        data_d  = acc ? s_tdata : data_q;
        keep_d  = acc ? s_tkeep : keep_q;
        last_d  = acc ? s_tlast : last_q;
        sod_d   = 1'b0;
        en_d    = 1'b0;
        eod_d   = 1'b0;
        dat_d   = 1'b0;
        byte_d  = 8'h00;

        if (!hold) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cur_valid) begin
                        sod_d   = 1'b1;
                        idx_d   = '0;
                        state_d = ST_BYTES;
                    end
                end
                ST_BYTES: begin
                    if (cur_valid && cur_keep == '0) begin
                        bf_d = 1'b0;
                        if (cur_last) begin
                            en_d    = 1'b1;
                            state_d = ST_EOD;
                        end
                    end else if (cur_valid) begin
                        en_d   = 1'b1;
                        dat_d  = 1'b1;
                        byte_d = lanes[idx_q];
                        if (idx_q == cur_hi) begin
                            bf_d  = 1'b0;
                            idx_d = '0;
                            if (cur_last) state_d = ST_FLUSH;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    en_d    = 1'b1;
                    state_d = ST_EOD;
                end
                ST_EOD: begin
                    eod_d   = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        dec_d = '0;
        if (dat_d) dec_d[byte_d] = 1'b1;

        // Ready opens only in a quiet cycle, giving the one-cycle bubble.
        tready_d = ~hold & ~bf_d & ~(sod_d | en_d | eod_d)
                 & (state_d == ST_IDLE || state_d == ST_BYTES);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            bf_q     <= 1'b0;
            data_q   <= '0;
            keep_q   <= '0;
            last_q   <= 1'b0;
            tready_q <= 1'b0;
            sod_q    <= 1'b0;
            en_q     <= 1'b0;
            eod_q    <= 1'b0;
            byte_q   <= 8'h00;
            dec_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            bf_q     <= bf_d;
            data_q   <= data_d;
            keep_q   <= keep_d;
            last_q   <= last_d;
            tready_q <= tready_d;
            sod_q    <= sod_d;
            en_q     <= en_d;
            eod_q    <= eod_d;
            byte_q   <= byte_d;
            dec_q    <= dec_d;
        end
    end

endmodule
